br_pred_resolve_unit: RTL and testbench

- Branch/jump unit for the LA32R pipeline. Combines an IF-stage predictor (direct-mapped BHT of saturating counters plus a BTB) with an EX-stage resolver.
- The resolver decodes every LA32R branch/jump, computes the taken flag and target, and detects mispredictions. It drives the redirect PC and trains the tables on the next clock edge.

---
 rtl/br_pred_resolve_unit.sv | 160 ++++++++++++++++
 tb/tb_br_pred_resolve_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_pred_resolve_unit.sv
// Branch predictor (BHT of saturating counters + BTB, looked up at IF) and
// EX-stage branch/jump resolver for LA32R; trains the tables on the clock edge.
module br_pred_resolve_unit #(
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter bit STAT_EN     = 1'b1
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_inst,
  input  logic [31:0] ex_rd1,
  input  logic [31:0] ex_rd2,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        ex_is_branch,
  output logic        ex_taken,
  output logic [31:0] ex_target,
  output logic        ex_mispredict,
  output logic [31:0] ex_redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);
  localparam int IDX   = $clog2(BHT_ENTRIES);
  localparam int TAG_W = 30 - IDX;

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);

  localparam logic [5:0] OP_JIRL = 6'b010011;
  localparam logic [5:0] OP_B    = 6'b010100;
  localparam logic [5:0] OP_BL   = 6'b010101;
  localparam logic [5:0] OP_BEQ  = 6'b010110;
  localparam logic [5:0] OP_BNE  = 6'b010111;
  localparam logic [5:0] OP_BLT  = 6'b011000;
  localparam logic [5:0] OP_BGE  = 6'b011001;
  localparam logic [5:0] OP_BLTU = 6'b011010;
  localparam logic [5:0] OP_BGEU = 6'b011011;

  function automatic logic [CTR_BITS-1:0] ctr_inc(input logic [CTR_BITS-1:0] c);
    return (c == CTR_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [CTR_BITS-1:0] ctr_dec(input logic [CTR_BITS-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  logic                valid_q [BHT_ENTRIES];
  logic [TAG_W-1:0]    tag_q   [BHT_ENTRIES];
  logic [31:0]         tgt_q   [BHT_ENTRIES];
  logic [CTR_BITS-1:0] ctr_q   [BHT_ENTRIES];

  logic [IDX-1:0]   if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             lk_hit, ex_hit, is_uncond;
  logic [5:0]       opcode;
  logic [31:0]      off16, off26;
  logic signed [31:0] rj_s, rd_s;

  assign if_idx = if_pc[IDX+1:2];
  assign if_tag = if_pc[31:IDX+2];
  assign ex_idx = ex_pc[IDX+1:2];
  assign ex_tag = ex_pc[31:IDX+2];

  // IF lookup reads registered state only, so a same-cycle update is not visible
  assign lk_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = lk_hit && ctr_q[if_idx][CTR_BITS-1];
  assign pred_target = pred_taken ? tgt_q[if_idx] : if_pc + 32'd4;

  assign opcode = ex_inst[31:26];
  assign off16  = {{14{ex_inst[25]}}, ex_inst[25:10], 2'b00};
  assign off26  = {{4{ex_inst[9]}}, ex_inst[9:0], ex_inst[25:10], 2'b00};
  assign rj_s   = ex_rd1;
  assign rd_s   = ex_rd2;

  always_comb begin
    ex_is_branch = 1'b1;
    ex_taken     = 1'b0;
    is_uncond    = 1'b0;
    ex_target    = ex_pc + off16;
    case (opcode)
      OP_BEQ:  ex_taken = (ex_rd1 == ex_rd2);
      OP_BNE:  ex_taken = (ex_rd1 != ex_rd2);
      OP_BLT:  ex_taken = (rj_s < rd_s);
      OP_BGE:  ex_taken = (rj_s >= rd_s);
      OP_BLTU: ex_taken = (ex_rd1 < ex_rd2);
      OP_BGEU: ex_taken = (ex_rd1 >= ex_rd2);
      OP_B, OP_BL: begin
        ex_taken  = 1'b1;
        is_uncond = 1'b1;
        ex_target = ex_pc + off26;
      end
      OP_JIRL: begin
        ex_taken  = 1'b1;
        is_uncond = 1'b1;
        ex_target = ex_rd1 + off16;
      end
      default: ex_is_branch = 1'b0;
    endcase
  end

  // A non-branch that hits a taken entry (aliasing) is caught by the direction compare
  assign ex_mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                                       (ex_taken && (ex_target != ex_pred_target)));
  assign ex_redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
  assign ex_hit         = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (ex_valid) begin
      if (ex_is_branch && ex_taken) begin
        valid_q[ex_idx] <= 1'b1;
        ctr_q[ex_idx]   <= ex_hit ? ctr_inc(ctr_q[ex_idx]) : (is_uncond ? CTR_MAX : CTR_WT);
      end else if (ex_is_branch) begin
        if (ex_hit) ctr_q[ex_idx] <= ctr_dec(ctr_q[ex_idx]);
      end else if (ex_hit) begin
        valid_q[ex_idx] <= 1'b0;
      end
    end
  end

  // Tag/target are payload: only meaningful while the entry's valid bit is set
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst && ex_valid && ex_is_branch && ex_taken) begin
      tag_q[ex_idx] <= ex_tag;
      tgt_q[ex_idx] <= ex_target;
    end
  end

  if (STAT_EN) begin : g_stat
    logic [31:0] br_cnt_q, mp_cnt_q;
    always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
        br_cnt_q <= '0;
        mp_cnt_q <= '0;
      end else begin
        if (ex_valid && ex_is_branch) br_cnt_q <= sat_inc32(br_cnt_q);
        if (ex_mispredict)            mp_cnt_q <= sat_inc32(mp_cnt_q);
      end
    end
    assign stat_branches    = br_cnt_q;
    assign stat_mispredicts = mp_cnt_q;
  end else begin : g_no_stat
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
  end
endmodule

// File: tb/tb_br_pred_resolve_unit.sv
// Scoreboard bench for br_pred_resolve_unit: a table-level reference model
// predicts every cycle's outputs; a negedge monitor pops and compares them.
module tb_br_pred_resolve_unit;
  localparam int N = 64;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_inst, ex_rd1, ex_rd2;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_is_branch, ex_taken, ex_mispredict;
  logic [31:0] ex_target, ex_redirect_pc, stat_branches, stat_mispredicts;

  br_pred_resolve_unit #(.BHT_ENTRIES(N), .CTR_BITS(2), .STAT_EN(1'b1)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_inst(ex_inst),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_mispredict(ex_mispredict), .ex_redirect_pc(ex_redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic        pt;
    logic [31:0] ptgt;
    logic        br, tk, mp;
    logic [31:0] tgt, rpc, sb, sm;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: one record per table slot, counters as plain ints
  bit          m_valid [N];
  int unsigned m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  int unsigned m_sb, m_sm;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * N);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_sb = 0;
    m_sm = 0;
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output logic t, output logic [31:0] tg);
    int i;
    i  = idx_of(pc);
    t  = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
    tg = t ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic void m_resolve(input logic [31:0] pc, inst, rd1, rd2,
                                    output logic br, output logic tk, output logic unc,
                                    output logic [31:0] tgt);
    int op, o16, o26;
    logic [25:0] w;
    op  = int'(inst[31:26]);
    o16 = $signed(inst[25:10]) * 4;
    w   = {inst[9:0], inst[25:10]};
    o26 = $signed(w) * 4;
    br = 1'b1; tk = 1'b0; unc = 1'b0;
    tgt = pc + o16;
    case (op)
      'h16: tk = (rd1 == rd2);
      'h17: tk = (rd1 != rd2);
      'h18: tk = (int'(rd1) < int'(rd2));
      'h19: tk = (int'(rd1) >= int'(rd2));
      'h1a: tk = (longint'(rd1) < longint'(rd2));
      'h1b: tk = (longint'(rd1) >= longint'(rd2));
      'h14, 'h15: begin tk = 1'b1; unc = 1'b1; tgt = pc + o26; end
      'h13: begin tk = 1'b1; unc = 1'b1; tgt = rd1 + o16; end
      default: br = 1'b0;
    endcase
  endfunction

  function automatic void m_train(input logic [31:0] pc, input logic br, tk, unc, mp,
                                  input logic [31:0] tgt);
    int i;
    bit hit;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    if (br && tk) begin
      if (hit) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
      else begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(pc);
        m_ctr[i]   = unc ? 3 : 2;
      end
      m_tgt[i] = tgt;
    end else if (br) begin
      if (hit) m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
    end else if (hit) begin
      m_valid[i] = 1'b0;
    end
    if (br && m_sb != 32'hFFFF_FFFF) m_sb++;
    if (mp && m_sm != 32'hFFFF_FFFF) m_sm++;
  endfunction

  task automatic step(input logic rst, input logic [31:0] ipc, input logic v,
                      input logic [31:0] pc, inst, rd1, rd2,
                      input logic pt, input logic [31:0] ptg);
    exp_t e;
    logic br, tk, unc, lpt;
    logic [31:0] tg, lptg;
    @(posedge cpu_clk);
    #1;
    cpu_rst = rst; if_pc = ipc; ex_valid = v; ex_pc = pc; ex_inst = inst;
    ex_rd1 = rd1; ex_rd2 = rd2; ex_pred_taken = pt; ex_pred_target = ptg;
    m_lookup(ipc, lpt, lptg);
    m_resolve(pc, inst, rd1, rd2, br, tk, unc, tg);
    e.pt = lpt; e.ptgt = lptg; e.br = br; e.tk = tk; e.tgt = tg;
    e.mp = v && ((tk != pt) || (tk && tg != ptg));
    e.rpc = tk ? tg : pc + 32'd4;
    e.sb = m_sb; e.sm = m_sm;
    exp_q.push_back(e);
    if (rst) m_reset();
    else if (v) m_train(pc, br, tk, unc, e.mp, tg);
  endtask

  // Resolve with the prediction the front end would have attached to ex_pc
  task automatic stepp(input logic [31:0] ipc, pc, inst, rd1, rd2);
    logic pt;
    logic [31:0] ptg;
    m_lookup(pc, pt, ptg);
    step(1'b0, ipc, 1'b1, pc, inst, rd1, rd2, pt, ptg);
  endtask

  task automatic idle(input logic [31:0] ipc);
    step(1'b0, ipc, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] mk16(input logic [5:0] op, input logic [15:0] imm);
    logic [31:0] r;
    r = $urandom;
    r[31:26] = op;
    r[25:10] = imm;
    return r;
  endfunction

  function automatic logic [31:0] mk26(input logic [5:0] op, input logic [25:0] offs);
    logic [31:0] r;
    r[31:26] = op;
    r[25:10] = offs[15:0];
    r[9:0]   = offs[25:16];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  always @(negedge cpu_clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pred_taken", {31'b0, pred_taken}, {31'b0, e.pt});
      chk("pred_target", pred_target, e.ptgt);
      chk("ex_is_branch", {31'b0, ex_is_branch}, {31'b0, e.br});
      chk("ex_taken", {31'b0, ex_taken}, {31'b0, e.tk});
      if (e.br) chk("ex_target", ex_target, e.tgt);
      chk("ex_mispredict", {31'b0, ex_mispredict}, {31'b0, e.mp});
      chk("ex_redirect_pc", ex_redirect_pc, e.rpc);
      chk("stat_branches", stat_branches, e.sb);
      chk("stat_mispredicts", stat_mispredicts, e.sm);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  logic [5:0]  ops  [12] = '{6'h16, 6'h17, 6'h18, 6'h19, 6'h1a, 6'h1b,
                             6'h14, 6'h15, 6'h13, 6'h00, 6'h0a, 6'h3f};
  logic [31:0] vals [7]  = '{32'h0, 32'h1, 32'h5, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'h7FFF_FFFF, 32'h1c00_0040};

  initial begin : stimulus
    logic [31:0] beq8, pc, ipc, inst, ptg;
    logic pt;
    cpu_rst = 1'b1; if_pc = '0; ex_valid = 1'b0; ex_pc = '0; ex_inst = '0;
    ex_rd1 = '0; ex_rd2 = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    m_reset();
    repeat (2) @(posedge cpu_clk);

    idle(32'h1c00_0010);
    beq8 = mk16(6'h16, 16'd8);
    stepp(32'h1c00_0010, 32'h1c00_0100, beq8, 32'd5, 32'd5);
    idle(32'h1c00_0100);

    stepp(32'h1c00_0200, 32'h1c00_0200, mk16(6'h1a, 16'd4), 32'hFFFF_FFFF, 32'd1);
    stepp(32'h1c00_0200, 32'h1c00_0200, mk16(6'h18, 16'd4), 32'hFFFF_FFFF, 32'd1);
    stepp(32'h1c00_0200, 32'h1c00_0200, mk16(6'h1b, 16'd4), 32'hFFFF_FFFF, 32'd1);

    for (int k = 0; k < 4; k++) stepp(32'h1c00_0400, 32'h1c00_0400, beq8, 32'd7, 32'd7);
    for (int k = 0; k < 2; k++) stepp(32'h1c00_0400, 32'h1c00_0400, beq8, 32'd7, 32'd8);
    idle(32'h1c00_0400);

    stepp(32'h1c00_0300, 32'h1c00_0300, mk16(6'h13, 16'hFFFF), 32'h1c00_8000, 32'd0);
    stepp(32'h1c00_0800, 32'h1c00_0800, mk26(6'h15, 26'h3FF_FFFE), 32'd0, 32'd0);
    idle(32'h1c00_0800);

    stepp(32'h1c00_0500, 32'h1c00_0500, beq8, 32'd1, 32'd1);
    stepp(32'h1c00_0500, 32'h1c00_0500, 32'h0010_0000, 32'd1, 32'd1);
    idle(32'h1c00_0500);

    step(1'b1, 32'h1c00_0600, 1'b1, 32'h1c00_0600, beq8, 32'd3, 32'd3, 1'b0, 32'h0);
    idle(32'h1c00_0600);

    stepp(32'h1c00_0700, 32'h1c00_0700, beq8, 32'd2, 32'd2);
    idle(32'h1c00_0700);

    for (int k = 0; k < 800; k++) begin
      pc   = 32'h1c00_0000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 2) << 8);
      ipc  = ($urandom_range(0, 1) == 0) ? pc
           : 32'h1c00_0000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 2) << 8);
      inst = $urandom;
      inst[31:26] = ops[$urandom_range(0, 11)];
      m_lookup(pc, pt, ptg);
      if ($urandom_range(0, 3) == 0) begin
        pt  = 1'($urandom_range(0, 1));
        ptg = ($urandom_range(0, 1) == 0) ? pc + 32'd4 : $urandom;
      end
      step(($urandom_range(0, 99) == 0), ipc, ($urandom_range(0, 99) < 85), pc, inst,
           vals[$urandom_range(0, 6)], vals[$urandom_range(0, 6)], pt, ptg);
    end

    @(negedge cpu_clk);
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge cpu_clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
